// File: rtl/algorithm_reduce_pkg.sv
// Shared encodings for the stream reducer: fold modes and FSM states.
package algorithm_reduce_pkg;
  localparam int REDUCE_WRAP = 0;
  localparam int REDUCE_SAT  = 1;
  localparam int REDUCE_MIN  = 2;
  localparam int REDUCE_MAX  = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
endpackage

// File: rtl/algorithm_reduce_if.sv
// Start, stream and result handshakes of the reducer; slave is the reducer side.
interface algorithm_reduce_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] init;
  logic [WIDTH-1:0] sIn;
  logic             sIn_valid;
  logic             sIn_ready;
  logic             sIn_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic [CNT_W-1:0] count;
  logic             overflow;

  modport master (
    output in_valid, init, sIn, sIn_valid, sIn_last, out_ready,
    input  in_ready, sIn_ready, out_valid, sum, count, overflow
  );
  modport slave (
    input  in_valid, init, sIn, sIn_valid, sIn_last, out_ready,
    output in_ready, sIn_ready, out_valid, sum, count, overflow
  );
endinterface

// File: rtl/algorithm_reduce_reduce_op.sv
// Combinational fold step f(acc, x) for one MODE; reusable by other fold blocks.
module reduce_op
  import algorithm_reduce_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MODE  = REDUCE_WRAP
) (
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_x,
  output logic [WIDTH-1:0] o_acc,
  output logic             o_ovf
);
  logic [WIDTH:0] w_usum;
  logic           w_pos_ovf;
  logic           w_neg_ovf;
  logic           w_lt;
  logic           w_gt;

  assign w_usum    = {1'b0, i_acc} + {1'b0, i_x};
  // Signed overflow: operands share a sign that the wrapped sum does not.
  assign w_pos_ovf = ~i_acc[WIDTH-1] & ~i_x[WIDTH-1] &  w_usum[WIDTH-1];
  assign w_neg_ovf =  i_acc[WIDTH-1] &  i_x[WIDTH-1] & ~w_usum[WIDTH-1];
  assign w_lt      = $signed(i_x) < $signed(i_acc);
  assign w_gt      = $signed(i_x) > $signed(i_acc);

  always_comb begin
    o_acc = w_usum[WIDTH-1:0];
    o_ovf = 1'b0;
    case (MODE)
      REDUCE_SAT: begin
        o_ovf = w_pos_ovf | w_neg_ovf;
        if (w_pos_ovf)      o_acc = {1'b0, {(WIDTH-1){1'b1}}};
        else if (w_neg_ovf) o_acc = {1'b1, {(WIDTH-1){1'b0}}};
      end
      REDUCE_MIN: o_acc = w_lt ? i_x : i_acc;
      REDUCE_MAX: o_acc = w_gt ? i_x : i_acc;
      default:    o_ovf = w_usum[WIDTH];
    endcase
  end
endmodule

// File: rtl/algorithm_reduce.sv
// Stream reducer: seed on start, fold beats until the last one, hold the result until taken.
module algorithm_reduce
  import algorithm_reduce_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MODE  = REDUCE_WRAP,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              nrst,
  algorithm_reduce_if.slave bus
);
  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic [WIDTH-1:0] w_next_acc;
  logic             w_step_ovf;

  reduce_op #(.WIDTH(WIDTH), .MODE(MODE)) u_op (
    .i_acc (r_acc),
    .i_x   (bus.sIn),
    .o_acc (w_next_acc),
    .o_ovf (w_step_ovf)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.in_valid) begin
          r_acc   <= bus.init;
          r_count <= '0;
          r_ovf   <= 1'b0;
          r_state <= ST_ACCUM;
        end
        ST_ACCUM: if (bus.sIn_valid) begin
          r_acc <= w_next_acc;
          r_ovf <= r_ovf | w_step_ovf;
          // Count sticks at all-ones rather than wrapping.
          if (r_count != {CNT_W{1'b1}}) r_count <= r_count + CNT_W'(1);
          if (bus.sIn_last) r_state <= ST_DONE;
        end
        ST_DONE: if (bus.out_ready) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.sIn_ready = (r_state == ST_ACCUM);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.sum       = r_acc;
  assign bus.count     = r_count;
  assign bus.overflow  = r_ovf;
endmodule

// File: tb/tb_algorithm_reduce.sv
// Drives all four fold modes (plus a 2-bit-counter wrap-sum) in lockstep against a scoreboard.
module tb_algorithm_reduce;
  logic       clk = 1'b0;
  logic       nrst;
  logic       in_valid, sIn_valid, sIn_last, out_ready;
  logic [7:0] init, sIn;

  logic [3:0]       o_in_ready, o_sIn_ready, o_out_valid, o_ovf;
  logic [3:0][7:0]  o_sum;
  logic [3:0][15:0] o_cnt;
  logic [7:0]       c_sum;
  logic [1:0]       c_cnt;

  typedef struct {
    logic [3:0][7:0] sum;
    logic [3:0]      ovf;
    int              cnt;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_fail = 0;
  int m_acc[4];
  bit m_ovf[4];
  int m_cnt;

  always #5 clk = ~clk;

  for (genvar m = 0; m < 4; m++) begin : g_dut
    algorithm_reduce_if #(.WIDTH(8), .CNT_W(16)) bus ();
    assign bus.in_valid  = in_valid;
    assign bus.init      = init;
    assign bus.sIn       = sIn;
    assign bus.sIn_valid = sIn_valid;
    assign bus.sIn_last  = sIn_last;
    assign bus.out_ready = out_ready;
    assign o_in_ready[m]  = bus.in_ready;
    assign o_sIn_ready[m] = bus.sIn_ready;
    assign o_out_valid[m] = bus.out_valid;
    assign o_sum[m]       = bus.sum;
    assign o_cnt[m]       = bus.count;
    assign o_ovf[m]       = bus.overflow;
    algorithm_reduce #(.WIDTH(8), .MODE(m), .CNT_W(16)) dut (
      .clk(clk), .nrst(nrst), .bus(bus));
  end

  algorithm_reduce_if #(.WIDTH(8), .CNT_W(2)) cbus ();
  assign cbus.in_valid  = in_valid;
  assign cbus.init      = init;
  assign cbus.sIn       = sIn;
  assign cbus.sIn_valid = sIn_valid;
  assign cbus.sIn_last  = sIn_last;
  assign cbus.out_ready = out_ready;
  assign c_sum = cbus.sum;
  assign c_cnt = cbus.count;
  algorithm_reduce #(.WIDTH(8), .MODE(0), .CNT_W(2)) dut_c (
    .clk(clk), .nrst(nrst), .bus(cbus));

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int sx(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  task automatic model_fold(input int x);
    int s;
    for (int m = 0; m < 4; m++) begin
      case (m)
        0: begin
          s = m_acc[m] + x;
          if (s > 255) m_ovf[m] = 1'b1;
          m_acc[m] = s & 255;
        end
        1: begin
          s = sx(m_acc[m]) + sx(x);
          if (s > 127)       begin s = 127;  m_ovf[m] = 1'b1; end
          else if (s < -128) begin s = -128; m_ovf[m] = 1'b1; end
          m_acc[m] = s & 255;
        end
        2: if (sx(x) < sx(m_acc[m])) m_acc[m] = x;
        default: if (sx(x) > sx(m_acc[m])) m_acc[m] = x;
      endcase
    end
    m_cnt++;
  endtask

  task automatic start_red(input logic [7:0] v, input bit hold);
    chk("in_ready_idle", o_in_ready, 4'hf);
    in_valid = 1'b1;
    init = v;
    @(posedge clk); #1;
    for (int m = 0; m < 4; m++) begin m_acc[m] = v; m_ovf[m] = 1'b0; end
    m_cnt = 0;
    chk("start_taken", {o_in_ready, o_sIn_ready}, {4'h0, 4'hf});
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic beat(input logic [7:0] x, input bit last);
    exp_t e;
    int n = 0;
    sIn_valid = 1'b1; sIn = x; sIn_last = last;
    while (o_sIn_ready[0] !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) chk("beat_timeout", 0, 1);
    @(posedge clk); #1;
    model_fold(x);
    sIn_valid = 1'b0; sIn_last = 1'b0;
    if (last) begin
      for (int m = 0; m < 4; m++) begin e.sum[m] = m_acc[m][7:0]; e.ovf[m] = m_ovf[m]; end
      e.cnt = m_cnt;
      sb.push_back(e);
      chk("last_latency", o_out_valid, 4'hf);
    end
  endtask

  task automatic bubble(input int cycles);
    sIn_valid = 1'b0; sIn = 8'h77;
    repeat (cycles) begin @(posedge clk); #1; end
  endtask

  task automatic collect(input int hold, input bit b2b);
    exp_t e;
    int n = 0;
    while (o_out_valid[0] !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) chk("out_timeout", 0, 1);
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", o_out_valid, 4'hf);
      chk("hold_sum", o_sum, e.sum);
      @(posedge clk); #1;
    end
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("m%0d_sum", m), o_sum[m], e.sum[m]);
      chk($sformatf("m%0d_cnt", m), o_cnt[m], e.cnt);
      chk($sformatf("m%0d_ovf", m), o_ovf[m], e.ovf[m]);
    end
    chk("c_sum", c_sum, e.sum[0]);
    chk("c_cnt_sat", c_cnt, (e.cnt > 3) ? 3 : e.cnt);
    out_ready = 1'b1;
    if (b2b) in_valid = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("handshake_idle", o_out_valid, 4'h0);
    if (b2b) chk("b2b_not_taken", o_in_ready, 4'hf);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    nrst = 1'b0; in_valid = 1'b0; init = '0; sIn = '0;
    sIn_valid = 1'b0; sIn_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", o_in_ready, 4'hf);
    chk("rst_sIn_ready", o_sIn_ready, 4'h0);
    chk("rst_out_valid", o_out_valid, 4'h0);
    chk("rst_sum", o_sum, 0);
    chk("rst_cnt", o_cnt, 0);
    chk("rst_ovf", o_ovf, 4'h0);
    @(negedge clk) nrst = 1'b1;
    @(posedge clk); #1;

    // Wrap sum with carry-out, also saturating the 2-bit counter.
    start_red(8'h00, 1'b0);
    beat(8'h01, 0); beat(8'h02, 0); beat(8'h03, 0); beat(8'hff, 1);
    chk("t1_sum", o_sum[0], 8'h05);
    chk("t1_cnt", o_cnt[0], 4);
    chk("t1_ovf", o_ovf[0], 1);
    collect(0, 0);

    // Saturating sum clamps high, then low.
    start_red(8'h7f, 1'b0);
    beat(8'h01, 0); beat(8'h02, 1);
    chk("t2_sat_hi", o_sum[1], 8'h7f);
    chk("t2_ovf_hi", o_ovf[1], 1);
    collect(0, 0);
    start_red(8'h80, 1'b0);
    beat(8'hff, 1);
    chk("t2_sat_lo", o_sum[1], 8'h80);
    chk("t2_ovf_lo", o_ovf[1], 1);
    collect(0, 0);

    // Signed min / max across extremes.
    start_red(8'h00, 1'b0);
    beat(8'h05, 0); beat(8'hfb, 0); beat(8'h7f, 0); beat(8'h80, 1);
    chk("t3_min", o_sum[2], 8'h80);
    chk("t3_max", o_sum[3], 8'h7f);
    chk("t3_cnt", o_cnt[2], 4);
    collect(0, 0);

    // Stream beats offered while idle must stall.
    sIn_valid = 1'b1; sIn = 8'h33; sIn_last = 1'b1;
    @(posedge clk); #1;
    chk("idle_no_ready", o_sIn_ready, 4'h0);
    chk("idle_no_accept", o_cnt[0], m_cnt);
    sIn_valid = 1'b0; sIn_last = 1'b0;

    // Bubbles inside the stream, then a held-off result.
    start_red(8'h10, 1'b0);
    beat(8'h03, 0); bubble(2); beat(8'h04, 1);
    chk("t4_cnt", o_cnt[0], 2);
    chk("t4_sum", o_sum[0], 8'h17);
    collect(5, 0);

    // Start held high through the stream: no re-seed; then back-to-back.
    start_red(8'h20, 1'b1);
    init = 8'h55;
    beat(8'h01, 0); beat(8'h02, 1);
    chk("t5_no_reseed", o_sum[0], 8'h23);
    in_valid = 1'b0;
    collect(1, 1);
    start_red(8'h40, 1'b0);
    beat(8'h40, 1);
    collect(0, 0);

    // Asynchronous reset mid-stream discards the partial result.
    start_red(8'h09, 1'b0);
    beat(8'h01, 0); beat(8'h02, 0);
    nrst = 1'b0;
    #2;
    chk("ar_in_ready", o_in_ready, 4'hf);
    chk("ar_sIn_ready", o_sIn_ready, 4'h0);
    chk("ar_out_valid", o_out_valid, 4'h0);
    chk("ar_sum", o_sum, 0);
    chk("ar_cnt", o_cnt, 0);
    chk("ar_ovf", o_ovf, 4'h0);
    @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;
    start_red(8'h03, 1'b0);
    beat(8'h04, 1);
    chk("t6_sum", o_sum[0], 8'h07);
    chk("t6_cnt", o_cnt[0], 1);
    collect(0, 0);

    chk("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
